// File: rtl/map_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// map_access_arbiter: shares one single-port map RAM between the draw engine
// and two player ropes (draw priority, burst-limited, players round-robin).
// Revision: 1.0
// ============================================================================
module map_access_arbiter #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int RAM_LAT        = 1,
    parameter int MAX_DRAW_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [2:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] c_wait_load = 3'(RAM_LAT - 1);
    localparam logic [3:0] c_max_burst = 4'(MAX_DRAW_BURST);

    logic [1:0] r_state;
    logic [1:0] r_sel;
    logic       r_wren;
    logic       r_last_p2;
    logic [3:0] r_draw_burst;
    logic [2:0] r_wait_cnt;

    logic       w_player_pend;
    logic       w_grant_draw;
    logic [1:0] w_grant_sel;

    always_comb begin
        w_player_pend = req[1] | req[2];
        w_grant_draw  = req[0] & (~w_player_pend | (r_draw_burst < c_max_burst));
        w_grant_sel   = 2'd0;
        if (w_grant_draw) begin
            w_grant_sel = 2'd0;
        end else if (req[1] & req[2]) begin
            w_grant_sel = r_last_p2 ? 2'd1 : 2'd2;
        end else if (req[1]) begin
            w_grant_sel = 2'd1;
        end else begin
            w_grant_sel = 2'd2;
        end
    end

    // Gating with reset keeps an in-flight write from reaching the RAM.
    assign ram_wren = r_wren & ~reset;
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sel        <= 2'd0;
            r_wren       <= 1'b0;
            r_last_p2    <= 1'b1;
            r_draw_burst <= 4'd0;
            r_wait_cnt   <= 3'd0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            done         <= 3'b000;
            rdata        <= '0;
        end else begin
            r_wren <= 1'b0;
            done   <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (req != 3'b000) begin
                        r_sel   <= w_grant_sel;
                        r_state <= S_ACCESS;
                        case (w_grant_sel)
                            2'd1: begin
                                ram_addr     <= addr1;
                                ram_wdata    <= wdata1;
                                r_wren       <= we1;
                                r_draw_burst <= 4'd0;
                                r_last_p2    <= 1'b0;
                            end
                            2'd2: begin
                                ram_addr     <= addr2;
                                ram_wdata    <= wdata2;
                                r_wren       <= we2;
                                r_draw_burst <= 4'd0;
                                r_last_p2    <= 1'b1;
                            end
                            default: begin
                                ram_addr  <= addr0;
                                ram_wdata <= '0;
                                r_wren    <= 1'b0;
                                // Burst only counts grants that held a player off.
                                if (w_player_pend) begin
                                    if (r_draw_burst != 4'hF) begin
                                        r_draw_burst <= r_draw_burst + 4'd1;
                                    end
                                end else begin
                                    r_draw_burst <= 4'd0;
                                end
                            end
                        endcase
                    end
                end
                S_ACCESS: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= c_wait_load;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state <= S_DONE;
                        rdata   <= ram_q;
                        done    <= 3'b001 << r_sel;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
- Shares the single-port map RAM between three requesters: draw engine (port 0), player 1 rope (port 1) and player 2 rope (port 2).
- Serializes requests, drives the RAM address, write data and write enable, waits out the RAM read latency, then returns read data with a one-cycle done pulse.
- Arbitration policy: draw has priority, players alternate round-robin, and a burst limit prevents the draw engine from starving the players.

Parameters:
- ADDR_W, 4, map RAM address width.
- DATA_W, 32, map entry width.
- RAM_LAT, 1, cycles from RAM address/wren valid to valid ram_q. Legal range 1..4.
- MAX_DRAW_BURST, 4, maximum consecutive draw grants while any player request is pending. Legal range 1..15.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  3  {p2, p1, draw} request levels. Held high until the matching done bit.
- we1  in  1  player 1 request is a write. Sampled at grant.
- we2  in  1  player 2 request is a write. Sampled at grant.
- addr0  in  ADDR_W  draw address.
- addr1  in  ADDR_W  player 1 address.
- addr2  in  ADDR_W  player 2 address.
- wdata1  in  DATA_W  player 1 write data.
- wdata2  in  DATA_W  player 2 write data.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_wren  out  1  RAM write enable, registered, one-cycle pulse.
- ram_q  in  DATA_W  RAM read data.
- done  out  3  one-hot completion pulse, registered.
- rdata  out  DATA_W  data returned for the completed transaction, registered.
- busy  out  1  high whenever state is not S_IDLE.

Behaviour:
- Reset: all outputs are 0 (ram_addr, ram_wdata, ram_wren, done, rdata, busy). Internal state: state=S_IDLE, sel=0, last_player=2, draw_burst=0.
- Reset has priority over every state. Reset during S_ACCESS forces ram_wren=0 in that cycle, so no write occurs. A transaction in flight when reset hits never produces a done pulse.
- FSM states: S_IDLE -> S_ACCESS -> S_WAIT -> S_DONE -> S_IDLE.
- S_IDLE, arbitration on sampled req:
  - Player pending = req[1] | req[2].
  - If req[0] and (no player pending, or draw_burst < MAX_DRAW_BURST): grant draw.
  - Otherwise, if both players request: grant the player not equal to last_player.
  - Otherwise grant the single requesting player.
  - If req == 0: stay in S_IDLE.
  - On grant: latch sel, ram_addr, ram_wdata (wdata of the selected player; 0 for draw) and the write flag (0 for draw; draw can never write). Next state S_ACCESS.
- S_ACCESS (1 cycle):
  - ram_wren = write flag in this cycle only; it is 0 in every other state.
  - ram_addr and ram_wdata are stable from S_ACCESS through S_DONE.
- S_WAIT: stays RAM_LAT cycles using a down-counter loaded on entry, then goes to S_DONE.
- S_DONE (1 cycle):
  - rdata <= ram_q. For writes the RAM returns the written data, so rdata equals the write data.
  - done[sel] = 1 for exactly this cycle.
  - Next state S_IDLE.
- Counters and pointers, updated on grant:
  - Draw grant: draw_burst increments (saturating at 15) if a player request was pending, else draw_burst clears.
  - Player grant: draw_burst clears and last_player <= granted player.
- Latency: req seen in S_IDLE at cycle T gives ram_wren/addr at T+1 and done at T+2+RAM_LAT. Back-to-back transactions are 3+RAM_LAT cycles apart.
- Handshake: the requester drops req on the clock edge ending its done cycle, so S_IDLE never re-grants a finished request. If req drops mid-transaction, the transaction still completes and still pulses done.
- Input changes: addr/wdata/we changes after grant are ignored.
- Simultaneous events: done and a new grant never occur in the same cycle. At most one done bit is high per cycle.

Test Plan:
- Single draw read: reset, RAM[3]=0xDEADBEEF, RAM_LAT=1, req=001, addr0=3 -> ram_addr=3 one cycle later, ram_wren never high, done=001 three cycles after the grant cycle, rdata=0xDEADBEEF.
- Player write then read: req=010, we1=1, addr1=5, wdata1=0x12345678 -> one ram_wren pulse at addr 5, done=010, rdata=0x12345678. Then we1=0 read of addr 5 -> rdata=0x12345678.
- Round-robin: req=110 held continuously (each requester re-raises req after its done) -> grant order p1, p2, p1, p2. done alternates 010/100.
- Draw starvation guard: MAX_DRAW_BURST=4, req[0] always high, req[1] high -> four draw dones, then one player 1 done, then draw resumes.
- Reset mid-write: assert reset in the S_ACCESS cycle of a p2 write to addr 7 -> ram_wren=0, no done, RAM[7] unchanged, busy=0 the next cycle.
- Latency sweep: RAM_LAT=3 draw read -> done exactly 5 cycles after the grant cycle. busy high from grant+1 through the done cycle inclusive.
